// File: rtl/ram_loader.sv
// Framed byte-stream boot loader: assembles big-endian words and
// drives the 16-bit main RAM write port one word at a time.
module ram_loader (
  input  logic        clk,
  input  logic        reset_bar,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] ram_address,
  output logic [15:0] ram_data,
  output logic        ram_load_bar,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    S_ADDR_HI,
    S_ADDR_LO,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_SUM_HI,
    S_SUM_LO,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] addr_q;
  logic [15:0] cnt_q;
  logic [15:0] sum_q;
  logic [15:0] data_q;
  logic [7:0]  hi_q;
  logic        load_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        xfer;

  assign in_ready = reset_bar && (state != S_WRITE) && (state != S_DONE);
  assign xfer     = in_valid && in_ready;

  assign ram_address = addr_q;
  assign ram_data    = data_q;
  // Strobe is forced high while reset is held so an aborted word never lands.
  assign ram_load_bar = load_q | ~reset_bar;
  assign busy  = busy_q;
  assign done  = done_q;
  assign error = err_q;

  always_comb begin
    state_nx = state;
    case (state)
      S_ADDR_HI: if (xfer) state_nx = S_ADDR_LO;
      S_ADDR_LO: if (xfer) state_nx = S_CNT_HI;
      S_CNT_HI:  if (xfer) state_nx = S_CNT_LO;
      S_CNT_LO:
        if (xfer)
          state_nx = ({cnt_q[15:8], in_byte} == 16'd0) ? S_SUM_HI : S_DATA_HI;
      S_DATA_HI: if (xfer) state_nx = S_DATA_LO;
      S_DATA_LO: if (xfer) state_nx = S_WRITE;
      S_WRITE:   state_nx = (cnt_q == 16'd1) ? S_SUM_HI : S_DATA_HI;
      S_SUM_HI:  if (xfer) state_nx = S_SUM_LO;
      S_SUM_LO:  if (xfer) state_nx = S_DONE;
      S_DONE:    state_nx = S_ADDR_HI;
      default:   state_nx = S_ADDR_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_bar) begin
      state  <= S_ADDR_HI;
      addr_q <= '0;
      cnt_q  <= '0;
      sum_q  <= '0;
      data_q <= '0;
      hi_q   <= '0;
      load_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      load_q <= 1'b1;
      done_q <= 1'b0;
      case (state)
        S_ADDR_HI:
          if (xfer) begin
            addr_q[15:8] <= in_byte;
            sum_q        <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b1;
          end
        S_ADDR_LO: if (xfer) addr_q[7:0] <= in_byte;
        S_CNT_HI:  if (xfer) cnt_q[15:8] <= in_byte;
        S_CNT_LO:  if (xfer) cnt_q[7:0]  <= in_byte;
        S_DATA_HI: if (xfer) hi_q <= in_byte;
        S_DATA_LO:
          if (xfer) begin
            data_q <= {hi_q, in_byte};
            load_q <= 1'b0;
          end
        S_WRITE: begin
          addr_q <= addr_q + 16'd1;
          cnt_q  <= cnt_q - 16'd1;
          sum_q  <= sum_q + data_q;
        end
        S_SUM_HI: if (xfer) hi_q <= in_byte;
        S_SUM_LO:
          if (xfer) begin
            done_q <= 1'b1;
            err_q  <= ({hi_q, in_byte} != sum_q);
          end
        S_DONE:  busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: frames built from a list model,
// RAM writes and done/error checked by a negedge monitor.
module tb_ram_loader;

  logic        clk = 1'b0;
  logic        reset_bar = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] ram_address;
  logic [15:0] ram_data;
  logic        ram_load_bar;
  logic        busy;
  logic        done;
  logic        error;

  ram_loader dut (
    .clk(clk),
    .reset_bar(reset_bar),
    .in_byte(in_byte),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .ram_address(ram_address),
    .ram_data(ram_data),
    .ram_load_bar(ram_load_bar),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic err;
    int   lat;
  } dn_t;

  wr_t wq[$];
  dn_t dq[$];
  wr_t w_m;
  dn_t d_m;

  int   checks = 0;
  int   fails = 0;
  logic err_exp = 1'b0;
  bit   start_flag = 1'b0;
  int   since = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: RAM port, done pulse, sticky error
  always @(negedge clk) begin
    if (start_flag) begin
      since = 1;
      start_flag = 1'b0;
    end else begin
      since++;
    end
    if (reset_bar) begin
      if (!ram_load_bar) begin
        chk("ready_in_write", in_ready, 0);
        if (wq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_write: addr %h data %h, none expected",
                   ram_address, ram_data);
        end else begin
          w_m = wq.pop_front();
          chk("wr_addr", ram_address, w_m.a);
          chk("wr_data", ram_data, w_m.d);
          chk("busy_in_write", busy, 1);
        end
      end
      if (done) begin
        chk("ready_in_done", in_ready, 0);
        if (dq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done: got done=1 expected 0");
        end else begin
          d_m = dq.pop_front();
          err_exp = d_m.err;
          if (d_m.lat >= 0) chk("done_latency", since, d_m.lat);
        end
      end
      chk("error", error, err_exp);
    end
  end

  task automatic send(input logic [7:0] b[$], input int gap);
    for (int i = 0; i < b.size(); i++) begin
      bit acc;
      int tries;
      acc = 1'b0;
      tries = 0;
      while (!acc) begin
        @(negedge clk);
        in_byte = b[i];
        in_valid = ($urandom_range(99) >= gap);
        #1;
        acc = in_valid && in_ready;
        @(posedge clk);
        if (acc && i == 0) begin
          err_exp = 1'b0;
          start_flag = 1'b1;
        end
        tries++;
        if (!acc && tries > 200) begin
          checks++;
          fails++;
          $display("FAIL byte_stall: byte %0d not accepted, got 0 expected 1", i);
          #1 in_valid = 1'b0;
          return;
        end
      end
    end
    #1 in_valid = 1'b0;
  endtask

  // Reference model: expected writes, checksum verdict and latency
  task automatic frame(input logic [15:0] a, input logic [15:0] w[$],
                       input int adj, input int gap);
    logic [7:0]  b[$];
    logic [15:0] s;
    logic [15:0] n;
    logic [15:0] rx;
    wr_t         t;
    dn_t         d;
    s = 16'd0;
    n = 16'(w.size());
    b.push_back(a[15:8]);
    b.push_back(a[7:0]);
    b.push_back(n[15:8]);
    b.push_back(n[7:0]);
    for (int i = 0; i < w.size(); i++) begin
      b.push_back(w[i][15:8]);
      b.push_back(w[i][7:0]);
      t.a = a + 16'(i);
      t.d = w[i];
      wq.push_back(t);
      s = s + w[i];
    end
    rx = s + 16'(adj);
    b.push_back(rx[15:8]);
    b.push_back(rx[7:0]);
    d.err = (rx != s);
    d.lat = (gap == 0) ? 4 + 3 * w.size() + 2 : -1;
    dq.push_back(d);
    send(b, gap);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ws[$];
    logic [7:0]  pb[$];

    reset_bar = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_load_bar", ram_load_bar, 1);
    chk("rst_address", ram_address, 0);
    chk("rst_data", ram_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    reset_bar = 1'b1;
    #1;
    chk("idle_ready", in_ready, 1);

    ws = {16'h1234, 16'hABCD};
    frame(16'h1000, ws, 0, 0);
    frame(16'h1000, ws, 1, 0);
    repeat (3) @(negedge clk);
    chk("error_sticky", error, 1);
    chk("idle_busy", busy, 0);

    ws = {16'h0001, 16'h0002};
    frame(16'hFFFF, ws, 0, 0);

    ws.delete();
    frame(16'h2000, ws, 0, 0);

    ws = {16'h5A5A, 16'h0F0F, 16'hC3C3};
    frame(16'h3000, ws, 0, 0);
    frame(16'h3000, ws, 0, 50);

    pb = {8'h40, 8'h00, 8'h00, 8'h02, 8'h77, 8'h88};
    send(pb, 0);
    reset_bar = 1'b0;
    @(posedge clk);
    err_exp = 1'b0;
    #1;
    chk("abort_load_bar", ram_load_bar, 1);
    chk("abort_busy", busy, 0);
    chk("abort_ready", in_ready, 0);
    reset_bar = 1'b1;
    ws = {16'h1111, 16'h2222};
    frame(16'h4000, ws, 0, 0);

    for (int f = 0; f < 8; f++) begin
      logic [15:0] a;
      int          adj;
      int          cnt;
      a = 16'($urandom);
      if (f == 0) a = 16'hFFFE;
      cnt = $urandom_range(4);
      ws.delete();
      for (int i = 0; i < cnt; i++) ws.push_back(16'($urandom));
      adj = $urandom_range(1) ? $urandom_range(16'hFFFF, 1) : 0;
      frame(a, ws, adj, $urandom_range(1) ? 40 : 0);
    end

    repeat (20) @(negedge clk);
    chk("writes_drained", wq.size(), 0);
    chk("dones_drained", dq.size(), 0);
    chk("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
